// File: rtl/reg_access_master.sv
// Initiator for the register select/read-write bus: takes one command at a time,
// issues a single-cycle one-hot strobe, waits out the read latency and responds.
module reg_access_master #(
  parameter int REG_WIDTH  = 32,
  parameter int REG_NUM    = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int RD_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_wr_rd,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic [REG_WIDTH-1:0]         req_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [REG_WIDTH-1:0]         rsp_rdata,
  output logic                         rsp_err,
  output logic [REG_NUM-1:0]           reg_wr_sel,
  output logic                         reg_wr_rd,
  output logic [REG_WIDTH-1:0]         reg_wr_data,
  input  logic [REG_NUM*REG_WIDTH-1:0] reg_rd_in
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [ADDR_WIDTH:0] REG_NUM_W = (ADDR_WIDTH + 1)'(REG_NUM);
  localparam logic [3:0]          LAT_INIT  = 4'(RD_LATENCY - 1);

  state_t                  state_q, state_d;
  logic                    wr_rd_q, wr_rd_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [REG_WIDTH-1:0]    wdata_q, wdata_d;
  logic [REG_WIDTH-1:0]    rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [3:0]              cnt_q, cnt_d;

  logic                    addr_ok;
  logic [REG_NUM-1:0]      sel_dec;
  logic [REG_WIDTH-1:0]    rd_slice;

  assign addr_ok = ({1'b0, req_addr} < REG_NUM_W);

  // Latched address drives both the one-hot select and the read-slice mux.
  always_comb begin
    sel_dec  = '0;
    rd_slice = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (addr_q == ADDR_WIDTH'(i)) begin
        sel_dec[i] = 1'b1;
        rd_slice   = reg_rd_in[i*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_rd_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_rd_q <= wr_rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_rd_d = wr_rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_rd_d = req_wr_rd;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (addr_ok) begin
            state_d = ACCESS;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        if (wr_rd_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = LAT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d = rd_slice;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decode straight from state so reset kills a strobe at once.
  always_comb begin
    req_ready   = (state_q == IDLE);
    rsp_valid   = (state_q == RESP);
    rsp_rdata   = rdata_q;
    rsp_err     = err_q;
    reg_wr_sel  = '0;
    reg_wr_rd   = 1'b0;
    reg_wr_data = '0;
    if (state_q == ACCESS) begin
      reg_wr_sel  = sel_dec;
      reg_wr_rd   = wr_rd_q;
      reg_wr_data = wr_rd_q ? wdata_q : '0;
    end
  end

endmodule

// File: doc/reg_access_master.md
Name: reg_access_master

Overview:
- Initiator side of the register select/read-write bus.
- Accepts one register access per request over a valid/ready command interface, then decodes the word address into a one-hot register select.
- Drives a single-cycle select/write-enable/data strobe onto the bus, waits the programmed read latency, captures the addressed register's read bus and returns a response over a valid/ready response interface.
- Sits between the test/CPU-side command source and the bank of register blocks. One access outstanding at a time.

Parameters:
- REG_WIDTH, 32, data width of each register and of all data ports.
- REG_NUM, 8, number of attached registers (1..64); width of select vector.
- ADDR_WIDTH, 6, width of word-index address; must satisfy 2^ADDR_WIDTH >= REG_NUM.
- RD_LATENCY, 1, cycles from the select strobe to valid read data on reg_rd_in (1..15).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  command valid.
- req_ready  output  1  master can accept a command.
- req_wr_rd  input  1  1: write; 0: read.
- req_addr  input  ADDR_WIDTH  register word index.
- req_wdata  input  REG_WIDTH  write data.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumed.
- rsp_rdata  output  REG_WIDTH  read data; 0 for writes and errors.
- rsp_err  output  1  address out of range (req_addr >= REG_NUM).
- reg_wr_sel  output  REG_NUM  one-hot register select strobe.
- reg_wr_rd  output  1  1: write; 0: read; qualified by reg_wr_sel.
- reg_wr_data  output  REG_WIDTH  write data to registers.
- reg_rd_in  input  REG_NUM*REG_WIDTH  concatenated read buses; register i occupies bits [i*REG_WIDTH +: REG_WIDTH].

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_n). Everything in this block runs on that clock and reset.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, reg_wr_sel=0, reg_wr_rd=0, reg_wr_data=0, latency counter=0.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - req_ready=1 only in IDLE.
  - On req_valid&req_ready, latch wr_rd, addr and wdata.
  - Out-of-range address: go to RESP with rsp_err=1, rsp_rdata=0; no bus strobe.
  - Otherwise: go to ACCESS.
- ACCESS (exactly one cycle):
  - reg_wr_sel has a single bit set at the latched addr.
  - reg_wr_rd = latched wr_rd.
  - reg_wr_data = latched wdata for writes, 0 for reads.
  - Write: go to RESP.
  - Read: load counter with RD_LATENCY-1 and go to WAIT.
- Outside ACCESS: reg_wr_sel=0, reg_wr_rd=0, reg_wr_data=0. No strobe is ever longer than one cycle.
- WAIT:
  - Counter decrements each cycle.
  - When counter==0, capture reg_rd_in slice[addr] into rsp_rdata (rsp_err=0) and go to RESP.
  - Result: if the strobe is in cycle A, data is sampled at the end of cycle A+RD_LATENCY.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_ready.
  - On rsp_valid&rsp_ready, clear rsp_valid, rsp_rdata and rsp_err, and return to IDLE. The next command can be accepted in the following cycle (req_ready=1 then).
- Latency, with command accepted in cycle T:
  - Write: strobe in T+1, rsp_valid in T+2.
  - Read: strobe in T+1, rsp_valid in T+2+RD_LATENCY.
  - Error: rsp_valid in T+1.
  - Each of these assumes rsp_ready is asserted the cycle rsp_valid rises.
- Back-pressure: rsp_ready low keeps the FSM in RESP indefinitely. req_ready stays 0 and no further strobe is issued.
- req_* inputs are ignored outside IDLE. Commands presented while busy stay pending at the source, per the valid/ready rule.
- Reset asserted mid-operation, in any state:
  - Immediately clear all outputs to their reset values, including an in-flight select strobe.
  - Drop the pending response.
  - After reset release, resume in IDLE.
- Read data is taken only from the addressed slice. Other slices are ignored even if they are non-zero.

Test Plan:
- Write: REG_NUM=8, req addr=3, wr_rd=1, wdata=0x0000_0001 accepted at T -> in T+1, reg_wr_sel=8'b0000_1000, reg_wr_rd=1, reg_wr_data=0x1; strobe only in T+1; rsp_valid in T+2 with rsp_rdata=0, rsp_err=0.
- Read: RD_LATENCY=1; reg_rd_in slice 3 = 0x0000_0001 and slice 2 = 0xFFFF_FFFF; read addr=3 at T -> strobe in T+1 with reg_wr_rd=0 and reg_wr_data=0; rsp_valid in T+3 with rsp_rdata=0x1.
- Latency: RD_LATENCY=4, read addr 0 -> slice 0 changed from 0xA to 0xB in cycle A+4 is captured as 0xB; rsp_valid in T+6.
- Error: addr=9 with REG_NUM=8 -> reg_wr_sel stays 0 throughout; rsp_valid in T+1 with rsp_err=1, rsp_rdata=0.
- Back-pressure: rsp_ready held low 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable; req_ready=0; a second req_valid gets no strobe. After rsp_ready, the second command is accepted the cycle after the handshake.
- Reset: rst_n dropped in the ACCESS cycle -> reg_wr_sel=0 asynchronously; after release, req_ready=1, rsp_valid=0, and no response is ever produced for the aborted command.
